// File: rtl/sparc_window_regfile.sv
// SPARC windowed integer register file: two registered read ports, one write port
// with same-cycle bypass, hardwired %g0, and save/restore-managed window pointer.
module sparc_window_regfile #(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    input  logic                wr_en,
    input  logic [4:0]          wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                save,
    input  logic                restore,
    input  logic [NWINDOWS-1:0] wim,
    output logic [CWP_W-1:0]    cwp,
    output logic                trap_ovf,
    output logic                trap_unf
);

    localparam int unsigned WIN_N  = 16 * NWINDOWS;
    localparam int unsigned PHYS_N = 8 + WIN_N;
    localparam int          PHYS_W = $clog2(PHYS_N);

    typedef enum logic [1:0] {
        WIN_HOLD,
        WIN_SAVE,
        WIN_RESTORE
    } win_op_t;

    logic [DATA_W-1:0] regs [PHYS_N];

    logic [PHYS_W-1:0] rs1_idx;
    logic [PHYS_W-1:0] rs2_idx;
    logic [PHYS_W-1:0] wr_idx;
    logic              wr_act;
    logic [DATA_W-1:0] rs1_next;
    logic [DATA_W-1:0] rs2_next;
    logic [CWP_W-1:0]  cwp_dec;
    logic [CWP_W-1:0]  cwp_inc;
    win_op_t           win_op;

    // Unified physical index: globals occupy 0..7, windowed storage follows.
    // Ins of window w land on the outs of window w+1 through the modulo wrap.
    function automatic logic [PHYS_W-1:0] phys_idx(input logic [4:0] r,
                                                   input logic [CWP_W-1:0] w);
        logic [31:0] off;
        if (r < 5'd8) begin
            return PHYS_W'(r);
        end
        off = 32'(w) * 32'd16 + 32'(r) - 32'd8;
        if (off >= WIN_N) begin
            off = off - WIN_N;
        end
        return PHYS_W'(off + 32'd8);
    endfunction

    assign rs1_idx = phys_idx(rs1_addr, cwp);
    assign rs2_idx = phys_idx(rs2_addr, cwp);
    assign wr_idx  = phys_idx(wr_addr, cwp);
    assign wr_act  = wr_en && (wr_addr != '0);

    always_comb begin
        rs1_next = regs[rs1_idx];
        if (rs1_addr == '0) begin
            rs1_next = '0;
        end else if (wr_act && (wr_idx == rs1_idx)) begin
            rs1_next = wr_data;
        end
    end

    always_comb begin
        rs2_next = regs[rs2_idx];
        if (rs2_addr == '0) begin
            rs2_next = '0;
        end else if (wr_act && (wr_idx == rs2_idx)) begin
            rs2_next = wr_data;
        end
    end

    // Explicit wrap so non-power-of-two window counts stay modulo NWINDOWS.
    assign cwp_dec = (cwp == '0) ? CWP_W'(NWINDOWS - 1) : cwp - 1'b1;
    assign cwp_inc = (cwp == CWP_W'(NWINDOWS - 1)) ? '0 : cwp + 1'b1;

    always_comb begin
        win_op = WIN_HOLD;
        if (save && !restore) begin
            win_op = WIN_SAVE;
        end else if (restore && !save) begin
            win_op = WIN_RESTORE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_act) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cwp      <= CWP_W'(NWINDOWS - 1);
            rs1_data <= '0;
            rs2_data <= '0;
            trap_ovf <= 1'b0;
            trap_unf <= 1'b0;
        end else begin
            trap_ovf <= 1'b0;
            trap_unf <= 1'b0;
            if (rd_en) begin
                rs1_data <= rs1_next;
                rs2_data <= rs2_next;
            end
            case (win_op)
                WIN_SAVE: begin
                    if (wim[cwp_dec]) begin
                        trap_ovf <= 1'b1;
                    end else begin
                        cwp <= cwp_dec;
                    end
                end
                WIN_RESTORE: begin
                    if (wim[cwp_inc]) begin
                        trap_unf <= 1'b1;
                    end else begin
                        cwp <= cwp_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Scoreboard bench for sparc_window_regfile: an 8-window and a 5-window instance
// share stimulus; a behavioural model predicts each edge's outputs.
module tb_sparc_window_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic [7:0]  wim8 = '0;

    logic [31:0] r1_a, r2_a, r1_b, r2_b;
    logic [2:0]  cwp_a, cwp_b;
    logic        ovf_a, unf_a, ovf_b, unf_b;

    always #5 clk = ~clk;

    sparc_window_regfile #(.DATA_W(32), .NWINDOWS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(r1_a), .rs2_data(r2_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .save(save), .restore(restore), .wim(wim8),
        .cwp(cwp_a), .trap_ovf(ovf_a), .trap_unf(unf_a)
    );

    sparc_window_regfile #(.DATA_W(32), .NWINDOWS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(r1_b), .rs2_data(r2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .save(save), .restore(restore), .wim(wim8[4:0]),
        .cwp(cwp_b), .trap_ovf(ovf_b), .trap_unf(unf_b)
    );

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        int          cwp;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          nw    [2] = '{8, 5};
    int          m_cwp [2];
    logic [31:0] m_r1  [2];
    logic [31:0] m_r2  [2];
    logic        m_ovf [2];
    logic        m_unf [2];
    logic [31:0] m_glob[2][8];
    logic [31:0] m_win [2][128];

    // Architectural view: window w's register r>=8 lives at frame slot 16w+(r-8),
    // wrapping around the circular window stack.
    function automatic int slot(int i, int r);
        return (16 * m_cwp[i] + (r - 8)) % (16 * nw[i]);
    endfunction

    function automatic logic [31:0] arch_read(int i, int r);
        if (r == 0) return 32'h0;
        if (r < 8) return m_glob[i][r];
        return m_win[i][slot(i, r)];
    endfunction

    // One clock edge of the architecture: the write lands first, so a same-cycle
    // read naturally observes it; window moves take effect afterwards.
    task automatic model_edge(int i, logic rstn, logic rd, int a1, int a2, logic we,
                              int wa, logic [31:0] wd, logic sv, logic rs,
                              logic [7:0] wm);
        int nxt;
        exp_t e;
        if (!rstn) begin
            m_cwp[i] = nw[i] - 1;
            m_r1[i] = 0; m_r2[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end else begin
            if (we && wa != 0) begin
                if (wa < 8) m_glob[i][wa] = wd;
                else m_win[i][slot(i, wa)] = wd;
            end
            if (rd) begin
                m_r1[i] = arch_read(i, a1);
                m_r2[i] = arch_read(i, a2);
            end
            m_ovf[i] = 0; m_unf[i] = 0;
            if (sv && !rs) begin
                nxt = (m_cwp[i] + nw[i] - 1) % nw[i];
                if (wm[nxt]) m_ovf[i] = 1; else m_cwp[i] = nxt;
            end else if (rs && !sv) begin
                nxt = (m_cwp[i] + 1) % nw[i];
                if (wm[nxt]) m_unf[i] = 1; else m_cwp[i] = nxt;
            end
        end
        e.r1 = m_r1[i]; e.r2 = m_r2[i]; e.cwp = m_cwp[i];
        e.ovf = m_ovf[i]; e.unf = m_unf[i];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic step(logic rstn, logic rd, int a1, int a2, logic we, int wa,
                        logic [31:0] wd, logic sv, logic rs, logic [7:0] wm);
        @(negedge clk);
        rst_n = rstn; rd_en = rd;
        rs1_addr = 5'(a1); rs2_addr = 5'(a2);
        wr_en = we; wr_addr = 5'(wa); wr_data = wd;
        save = sv; restore = rs; wim8 = wm;
        for (int i = 0; i < 2; i++) model_edge(i, rstn, rd, a1, a2, we, wa, wd, sv, rs, wm);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0 && q1.size() > 0) begin
                e = q0.pop_front();
                chk("rs1_w8", r1_a, e.r1);
                chk("rs2_w8", r2_a, e.r2);
                chk("cwp_w8", 32'(cwp_a), 32'(e.cwp));
                chk("ovf_w8", 32'(ovf_a), 32'(e.ovf));
                chk("unf_w8", 32'(unf_a), 32'(e.unf));
                e = q1.pop_front();
                chk("rs1_w5", r1_b, e.r1);
                chk("rs2_w5", r2_b, e.r2);
                chk("cwp_w5", 32'(cwp_b), 32'(e.cwp));
                chk("ovf_w5", 32'(ovf_b), 32'(e.ovf));
                chk("unf_w5", 32'(unf_b), 32'(e.unf));
            end
        end
    end

    initial begin : driver
        int budget;
        logic [7:0] wm;
        logic sv, rs;
        for (int i = 0; i < 2; i++) begin
            m_cwp[i] = nw[i] - 1;
            m_r1[i] = 0; m_r2[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end

        // Reset with a write and a save that must be ignored.
        step(0, 1, 0, 0, 1, 9, 32'hBAD0BAD0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00);

        // Fill every global and every window slot (reads off until contents are known).
        for (int g = 1; g < 8; g++) step(1, 0, 0, 0, 1, g, $urandom, 0, 0, 8'h00);
        for (int w = 0; w < 8; w++)
            for (int k = 0; k < 16; k++)
                step(1, 0, 0, 0, 1, 8 + k, $urandom, k == 15, 0, 8'h00);

        // Reset mid-operation: write to r9 and save are dropped.
        step(0, 1, 3, 4, 1, 9, 32'hCAFEF00D, 1, 0, 8'h00);
        step(1, 1, 0, 9, 1, 0, 32'hDEADBEEF, 0, 0, 8'h00);
        step(1, 1, 9, 16, 1, 8, 32'h11111111, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 8'h00);
        step(1, 1, 24, 16, 0, 0, 32'h0, 0, 0, 8'h00);
        step(1, 1, 5, 5, 1, 5, 32'hA5A5A5A5, 0, 0, 8'h00);
        step(1, 1, 5, 24, 0, 0, 32'h0, 0, 1, 8'h00);
        // Overflow, pulse drop, then a clean save.
        step(1, 1, 1, 2, 0, 0, 32'h0, 1, 0, 8'h40);
        step(1, 1, 1, 2, 0, 0, 32'h0, 0, 0, 8'h40);
        step(1, 1, 1, 2, 0, 0, 32'h0, 1, 0, 8'h00);
        // Wrap through the top, underflow, then save+restore no-op.
        step(1, 1, 8, 31, 0, 0, 32'h0, 0, 1, 8'h00);
        step(1, 1, 8, 31, 0, 0, 32'h0, 0, 1, 8'h00);
        step(1, 1, 8, 31, 0, 0, 32'h0, 0, 1, 8'h02);
        step(1, 1, 8, 31, 0, 0, 32'h0, 0, 0, 8'h02);
        step(1, 1, 8, 31, 0, 0, 32'h0, 1, 1, 8'hFF);
        for (int k = 0; k < 6; k++) step(1, 1, 23, 24, 1, 31, $urandom, 0, 1, 8'h00);

        for (int n = 0; n < 2500; n++) begin
            sv = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 5) == 0);
            wm = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
            step($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom,
                 sv, rs, wm);
        end
        step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00);

        budget = 10;
        while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
